// File: rtl/event_packetizer.sv
// Timestamps rising edges on four event inputs, queues them, and streams each
// queued event as a 7-byte frame over a send/ready byte handshake.
module event_packetizer #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] time_value,
   input  logic        dg_out1,
   input  logic        dg_out2,
   input  logic        dg_out3,
   input  logic        pg_out,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_send,
   output logic        busy,
   output logic        overflow
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_LO} state_t;

   function automatic logic [7:0] frame_chk(input logic [7:0] flags, input logic [31:0] ts);
      return flags ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
   endfunction

   function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] flags,
                                             input logic [31:0] ts, input logic [7:0] chk);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         3'd0:    b = SYNC_BYTE;
         3'd1:    b = flags;
         3'd2:    b = ts[31:24];
         3'd3:    b = ts[23:16];
         3'd4:    b = ts[15:8];
         3'd5:    b = ts[7:0];
         3'd6:    b = chk;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   logic [3:0]       src;
   logic [3:0]       hist_q, hist_d, rise;
   logic             armed_q, armed_d;
   logic [35:0]      mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             drop_pend_q, drop_pend_d;
   logic             event_w, full, pop, push, drop;
   logic [3:0]       ent_flags_q, ent_flags_d;
   logic [31:0]      ent_time_q, ent_time_d;
   logic [7:0]       flags_byte_q, flags_byte_d;
   logic [7:0]       chk_q, chk_d;
   state_t           state_q;
   logic [2:0]       idx_q;
   logic [7:0]       tx_data_q;
   logic             tx_send_q, busy_q;

   assign src = {pg_out, dg_out3, dg_out2, dg_out1};

   always_comb begin
      hist_d  = src;
      armed_d = 1'b1;
      rise    = armed_q ? (src & ~hist_q) : 4'b0000;
      event_w = |rise;
      full    = (count_q == DEPTH_C);
      pop     = (state_q == IDLE) && (count_q != '0);
      // A full FIFO still accepts an event when the FSM frees a slot this cycle.
      push    = event_w && (!full || pop);
      drop    = event_w && full && !pop;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (!push && pop)
         count_d = count_q - 1'b1;

      overflow_d  = overflow_q | drop;
      drop_pend_d = drop_pend_q;
      if (state_q == LOAD)
         drop_pend_d = 1'b0;
      if (drop)
         drop_pend_d = 1'b1;

      ent_flags_d = ent_flags_q;
      ent_time_d  = ent_time_q;
      if (pop)
         {ent_flags_d, ent_time_d} = mem_q[rd_ptr_q];

      flags_byte_d = flags_byte_q;
      chk_d        = chk_q;
      if (state_q == LOAD) begin
         flags_byte_d = {drop_pend_q, 3'b000, ent_flags_q};
         chk_d        = frame_chk(flags_byte_d, ent_time_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q      <= 4'b0000;
         armed_q     <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         drop_pend_q <= 1'b0;
      end else begin
         hist_q      <= hist_d;
         armed_q     <= armed_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         drop_pend_q <= drop_pend_d;
      end
   end

   // Queue storage and frame contents carry no reset; control decides when they are valid.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= {rise, time_value};
      ent_flags_q  <= ent_flags_d;
      ent_time_q   <= ent_time_d;
      flags_byte_q <= flags_byte_d;
      chk_q        <= chk_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         idx_q     <= 3'd0;
         tx_data_q <= 8'h00;
         tx_send_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         tx_send_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
               end
            end
            LOAD: begin
               idx_q   <= 3'd0;
               state_q <= SEND;
            end
            SEND: begin
               if (tx_ready) begin
                  tx_data_q <= frame_byte(idx_q, flags_byte_q, ent_time_q, chk_q);
                  tx_send_q <= 1'b1;
                  state_q   <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               // The transmitter acknowledges a byte by dropping tx_ready.
               if (!tx_ready) begin
                  if (idx_q == 3'd6) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     state_q <= SEND;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_send  = tx_send_q;
   assign busy     = busy_q;
   assign overflow = overflow_q;

endmodule
